// File: rtl/tunnel_pkg.sv
// rtl/tunnel_pkg.sv - shared monitor state encodings, widths and tuning defaults
package tunnel_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    HOLDOFF  = 2'd2
  } mon_state_e;

  localparam int MIN_OVERLAP_DEFAULT    = 4;
  localparam int HOLDOFF_FRAMES_DEFAULT = 30;

  localparam int PIX_W = 10;
  localparam int OVL_W = 10;
  localparam int HIT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [OVL_W-1:0] sat_inc_ovl(input logic [OVL_W-1:0] v);
    return (v == {OVL_W{1'b1}}) ? v : v + {{(OVL_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [HIT_W-1:0] sat_inc_hit(input logic [HIT_W-1:0] v);
    return (v == {HIT_W{1'b1}}) ? v : v + {{(HIT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/collision_monitor_if.sv
// rtl/collision_monitor_if.sv - video-side inputs and game-side results of the collision monitor
interface collision_monitor_if;
  import tunnel_pkg::*;

  logic             arm;
  logic             frame_tick;
  logic             video_on;
  logic [PIX_W-1:0] pixel_row;
  logic [PIX_W-1:0] pixel_col;
  logic             icon_pix;
  logic             wall_pix;
  logic             clr_count;

  logic             collison_detect;
  logic [HIT_W-1:0] hit_count;
  logic [PIX_W-1:0] hit_row;
  logic [PIX_W-1:0] hit_col;
  logic [1:0]       mon_state;

  modport master (
    output arm, frame_tick, video_on, pixel_row, pixel_col, icon_pix, wall_pix, clr_count,
    input  collison_detect, hit_count, hit_row, hit_col, mon_state
  );

  modport slave (
    input  arm, frame_tick, video_on, pixel_row, pixel_col, icon_pix, wall_pix, clr_count,
    output collison_detect, hit_count, hit_row, hit_col, mon_state
  );

endinterface

// File: rtl/collision_monitor_overlap_counter.sv
// rtl/collision_monitor_overlap_counter.sv - per-frame overlap counter with first-pixel capture
module overlap_counter
  import tunnel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             overlap_i,
  input  logic [PIX_W-1:0] row_i,
  input  logic [PIX_W-1:0] col_i,
  output logic [OVL_W-1:0] count_o,
  output logic [PIX_W-1:0] cap_row_o,
  output logic [PIX_W-1:0] cap_col_o
);

  logic [OVL_W-1:0] count_q, count_d;
  logic             seen_q, seen_d;
  logic [PIX_W-1:0] cap_row_q, cap_row_d;
  logic [PIX_W-1:0] cap_col_q, cap_col_d;

  // load_i opens a new frame (a coincident overlap is its first pixel); run_i
  // accumulates within it; with neither asserted the frame is abandoned.
  always_comb begin
    count_d   = count_q;
    seen_d    = seen_q;
    cap_row_d = cap_row_q;
    cap_col_d = cap_col_q;
    if (load_i) begin
      count_d = {{(OVL_W-1){1'b0}}, overlap_i};
      seen_d  = overlap_i;
      if (overlap_i) begin
        cap_row_d = row_i;
        cap_col_d = col_i;
      end
    end else if (run_i) begin
      if (overlap_i) begin
        count_d = sat_inc_ovl(count_q);
        if (!seen_q) begin
          seen_d    = 1'b1;
          cap_row_d = row_i;
          cap_col_d = col_i;
        end
      end
    end else begin
      count_d = '0;
      seen_d  = 1'b0;
    end
  end

  // Counter and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      seen_q    <= 1'b0;
      cap_row_q <= '0;
      cap_col_q <= '0;
    end else begin
      count_q   <= count_d;
      seen_q    <= seen_d;
      cap_row_q <= cap_row_d;
      cap_col_q <= cap_col_d;
    end
  end

  assign count_o   = count_q;
  assign cap_row_o = cap_row_q;
  assign cap_col_o = cap_col_q;

endmodule

// File: rtl/collision_monitor.sv
// rtl/collision_monitor.sv - frame-based icon/wall collision detector with holdoff and hit counter
module collision_monitor
  import tunnel_pkg::*;
#(
  parameter int MIN_OVERLAP    = MIN_OVERLAP_DEFAULT,
  parameter int HOLDOFF_FRAMES = HOLDOFF_FRAMES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  collision_monitor_if.slave  bus
);

  localparam logic [OVL_W-1:0] MIN_OVL      = OVL_W'(MIN_OVERLAP);
  localparam logic [HIT_W-1:0] HOLDOFF_LOAD = HIT_W'(HOLDOFF_FRAMES);

  mon_state_e       state_q, state_d;
  logic [HIT_W-1:0] holdoff_q, holdoff_d;
  logic [HIT_W-1:0] hit_count_q, hit_count_d;
  logic [PIX_W-1:0] hit_row_q, hit_row_d;
  logic [PIX_W-1:0] hit_col_q, hit_col_d;
  logic             detect_q, detect_d;

  logic             overlap;
  logic             hit;
  logic             cnt_load;
  logic             cnt_run;
  logic [OVL_W-1:0] ovl_count;
  logic [PIX_W-1:0] cap_row;
  logic [PIX_W-1:0] cap_col;

  assign overlap = bus.video_on & bus.icon_pix & bus.wall_pix;

  overlap_counter u_overlap_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .run_i     (cnt_run),
    .overlap_i (overlap),
    .row_i     (bus.pixel_row),
    .col_i     (bus.pixel_col),
    .count_o   (ovl_count),
    .cap_row_o (cap_row),
    .cap_col_o (cap_col)
  );

  // Next-state, holdoff countdown and hit decision; arm low overrides everything.
  always_comb begin
    state_d   = state_q;
    holdoff_d = holdoff_q;
    hit       = 1'b0;
    if (!bus.arm) begin
      state_d   = DISARMED;
      holdoff_d = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (bus.frame_tick) state_d = ARMED;
        end
        ARMED: begin
          if (bus.frame_tick && (ovl_count >= MIN_OVL)) begin
            hit       = 1'b1;
            state_d   = HOLDOFF;
            holdoff_d = HOLDOFF_LOAD;
          end
        end
        HOLDOFF: begin
          if (bus.frame_tick) begin
            if (holdoff_q <= {{(HIT_W-1){1'b0}}, 1'b1}) begin
              state_d   = ARMED;
              holdoff_d = '0;
            end else begin
              holdoff_d = holdoff_q - {{(HIT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_d   = DISARMED;
          holdoff_d = '0;
        end
      endcase
    end
  end

  // A frame_tick that leaves us ARMED opens a fresh counting frame; between
  // ticks the counter only runs while ARMED and armed.
  always_comb begin
    cnt_load = bus.frame_tick && (state_d == ARMED);
    cnt_run  = bus.arm && !bus.frame_tick && (state_q == ARMED);
  end

  // Result registers: pulse, captured position and saturating hit count.
  always_comb begin
    detect_d    = hit;
    hit_row_d   = hit ? cap_row : hit_row_q;
    hit_col_d   = hit ? cap_col : hit_col_q;
    hit_count_d = hit_count_q;
    if (bus.clr_count) begin
      hit_count_d = hit ? {{(HIT_W-1){1'b0}}, 1'b1} : '0;
    end else if (hit) begin
      hit_count_d = sat_inc_hit(hit_count_q);
    end
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DISARMED;
      holdoff_q   <= '0;
      hit_count_q <= '0;
      hit_row_q   <= '0;
      hit_col_q   <= '0;
      detect_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      holdoff_q   <= holdoff_d;
      hit_count_q <= hit_count_d;
      hit_row_q   <= hit_row_d;
      hit_col_q   <= hit_col_d;
      detect_q    <= detect_d;
    end
  end

  assign bus.collison_detect = detect_q;
  assign bus.hit_count       = hit_count_q;
  assign bus.hit_row         = hit_row_q;
  assign bus.hit_col         = hit_col_q;
  assign bus.mon_state       = state_q;

endmodule
